gps_sv_sweeper: RTL and testbench

- Downstream control-and-capture stage for the LLKI-wrapped GPS core.
- Drives the core's sv_num/startRound inputs across a programmable range of satellite vehicles (SVs), then captures each round's ca_code, p_code and l_code when l_code_valid asserts.
- Buffers the results in a small FIFO and presents them to the host-side register logic over a valid/ready interface.

---
 rtl/gps_sv_sweeper.sv | 175 +++++++++++++++++
 tb/tb_gps_sv_sweeper.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_sv_sweeper.sv
// SV sweep controller and result-capture FIFO for the GPS core.
// Define GPS_SWEEP_PARITY_EN to add the out_parity port and per-entry parity.
module gps_sv_sweeper #(
  parameter int SV_FIRST       = 1,
  parameter int SV_LAST        = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         sys_clk_50,
  input  logic         rst_n,
  input  logic         sweep_start,
  output logic         sweep_busy,
  output logic         sweep_done,
  output logic         timeout_err,
  output logic [5:0]   sv_num,
  output logic         startRound,
  input  logic [12:0]  ca_code,
  input  logic [127:0] p_code,
  input  logic [127:0] l_code,
  input  logic         l_code_valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [5:0]   out_sv,
  output logic [12:0]  out_ca,
  output logic [127:0] out_p,
  output logic [127:0] out_l,
  output logic [4:0]   fifo_count
`ifdef GPS_SWEEP_PARITY_EN
  ,
  output logic         out_parity
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_DISARM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_PUSH   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  typedef struct packed {
    logic [5:0]   sv;
    logic [12:0]  ca;
    logic [127:0] p;
    logic [127:0] l;
  } ent_t;

  logic [2:0]    r_state;
  logic [5:0]    r_sv;
  logic [TW-1:0] r_cnt;
  logic          r_terr;
  ent_t          r_cap;
  ent_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [4:0]    r_count;

  logic [TW-1:0] w_cnt_inc;
  logic          w_push;
  logic          w_pop;
  logic          w_tmo;
  logic          w_adv;
  logic          w_last;
  ent_t          w_head;

  assign w_cnt_inc = r_cnt + TW'(1);
  assign w_last    = (r_sv == 6'(SV_LAST));
  // a pop in the same cycle never makes room for the push
  assign w_push    = (r_state == S_PUSH) &&
                     (r_count < 5'(FIFO_DEPTH));
  // a valid in WAIT wins over an expiring counter
  assign w_tmo     = ((r_state == S_DISARM) ||
                      ((r_state == S_WAIT) && !l_code_valid)) &&
                     (w_cnt_inc == TW'(TIMEOUT_CYCLES - 1));
  assign w_adv     = w_push | w_tmo;
  assign w_pop     = out_valid & out_ready;
  assign w_head    = r_mem[r_rd];

  always_ff @(posedge sys_clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sv    <= '0;
      r_cnt   <= '0;
      r_terr  <= 1'b0;
      r_cap   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (sweep_start) begin
            r_sv    <= 6'(SV_FIRST);
            r_terr  <= 1'b0;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_state <= S_DISARM;
        end
        S_DISARM: begin
          r_cnt <= w_cnt_inc;
          if (!l_code_valid) r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (l_code_valid) begin
            r_cap   <= {r_sv, ca_code, p_code, l_code};
            r_state <= S_PUSH;
          end
        end
        S_PUSH: ;
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_tmo) r_terr <= 1'b1;
      // compare before increment so SV_LAST = 63 cannot wrap
      if (w_adv) begin
        if (w_last) begin
          r_state <= S_DONE;
        end else begin
          r_sv    <= r_sv + 6'd1;
          r_state <= S_LAUNCH;
        end
      end
    end
  end

  always_ff @(posedge sys_clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: ;
      endcase
    end
  end

`ifdef GPS_SWEEP_PARITY_EN
  logic r_par [FIFO_DEPTH];
`endif

  always_ff @(posedge sys_clk_50) begin
    if (w_push) begin
      r_mem[r_wr] <= r_cap;
`ifdef GPS_SWEEP_PARITY_EN
      r_par[r_wr] <= ^r_cap;
`endif
    end
  end

`ifdef GPS_SWEEP_PARITY_EN
  assign out_parity = out_valid & r_par[r_rd];
`endif

  assign out_valid   = (r_count != 5'd0);
  assign out_sv      = out_valid ? w_head.sv : '0;
  assign out_ca      = out_valid ? w_head.ca : '0;
  assign out_p       = out_valid ? w_head.p  : '0;
  assign out_l       = out_valid ? w_head.l  : '0;
  assign fifo_count  = r_count;
  assign sv_num      = r_sv;
  assign startRound  = (r_state == S_LAUNCH);
  assign sweep_done  = (r_state == S_DONE);
  assign sweep_busy  = (r_state != S_IDLE);
  assign timeout_err = r_terr;

endmodule

// File: tb/tb_gps_sv_sweeper.sv
// Directed bench for gps_sv_sweeper: SVs 1..6, 4-deep FIFO, 16-cycle timeout.
// A behavioural core model answers each startRound after a programmable gap.
module tb_gps_sv_sweeper;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sweep_start;
  logic         sweep_busy;
  logic         sweep_done;
  logic         timeout_err;
  logic [5:0]   sv_num;
  logic         startRound;
  logic [12:0]  ca_code;
  logic [127:0] p_code;
  logic [127:0] l_code;
  logic         l_code_valid;
  logic         out_valid;
  logic         out_ready;
  logic [5:0]   out_sv;
  logic [12:0]  out_ca;
  logic [127:0] out_p;
  logic [127:0] out_l;
  logic [4:0]   fifo_count;
`ifdef GPS_SWEEP_PARITY_EN
  logic         out_parity;
`endif

  always #10 clk = ~clk;

  gps_sv_sweeper #(
    .SV_FIRST(1), .SV_LAST(6),
    .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .sys_clk_50(clk), .rst_n(rst_n),
    .sweep_start(sweep_start),
    .sweep_busy(sweep_busy),
    .sweep_done(sweep_done),
    .timeout_err(timeout_err),
    .sv_num(sv_num), .startRound(startRound),
    .ca_code(ca_code), .p_code(p_code),
    .l_code(l_code), .l_code_valid(l_code_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sv(out_sv), .out_ca(out_ca),
    .out_p(out_p), .out_l(out_l),
    .fifo_count(fifo_count)
`ifdef GPS_SWEEP_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [12:0] f_ca(input logic [5:0] s);
    return {7'h2B, s};
  endfunction
  function automatic logic [127:0] f_p(input logic [5:0] s);
    return {64'hFEED_0000_0000_0000 | 64'(s),
            64'h0123_4567_89AB_CDEF};
  endfunction
  function automatic logic [127:0] f_l(input logic [5:0] s);
    return {64'(s) << 32, ~64'(s)};
  endfunction

  // core model knobs
  int           m_hold = 0;
  int           m_gap  = 10;
  int           m_skip = 0;
  bit           m_fix  = 0;
  logic [12:0]  fx_ca  = '0;
  logic [127:0] fx_p   = '0;
  logic [127:0] fx_l   = '0;

  initial begin
    logic [5:0] s;
    ca_code = '0; p_code = '0; l_code = '0;
    l_code_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (startRound) begin
        s = sv_num;
        repeat (m_hold) @(posedge clk);
        if (m_hold > 0) #1;
        l_code_valid = 1'b0;
        if (int'(s) != m_skip) begin
          repeat (m_gap) @(posedge clk);
          #1;
          ca_code = m_fix ? fx_ca : f_ca(s);
          p_code  = m_fix ? fx_p  : f_p(s);
          l_code  = m_fix ? fx_l  : f_l(s);
          l_code_valid = 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic [5:0]   sv;
    logic [12:0]  ca;
    logic [127:0] p;
    logic [127:0] l;
    int           c;
  } pop_t;

  pop_t pop_q [$];
  int   sr_sv [$];
  int   sr_cyc [$];
  int   te_cyc = -1;
  logic te_prev = 1'b0;

  always @(negedge clk) begin
    pop_t e;
    if (startRound) begin
      sr_sv.push_back(int'(sv_num));
      sr_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      e.sv = out_sv; e.ca = out_ca;
      e.p = out_p; e.l = out_l; e.c = cyc;
      pop_q.push_back(e);
    end
    if (timeout_err && !te_prev) te_cyc = cyc;
    te_prev = timeout_err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic clr();
    pop_q.delete();
    sr_sv.delete();
    sr_cyc.delete();
  endtask

  task automatic start_sweep();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!sweep_done && n < 3000) begin
      tick();
      n++;
    end
    chk(tag, sweep_done, 1);
  endtask

  task automatic wait_cnt(input string tag, input int v);
    int n = 0;
    while (int'(fifo_count) < v && n < 500) begin
      tick();
      n++;
    end
    chk(tag, fifo_count, v);
  endtask

  task automatic drain();
    int n = 0;
    while (out_valid && n < 200) begin
      tick();
      n++;
    end
    tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  sweep_busy, 0);
    chk({tag, "_done"},  sweep_done, 0);
    chk({tag, "_terr"},  timeout_err, 0);
    chk({tag, "_svnum"}, sv_num, 0);
    chk({tag, "_start"}, startRound, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_osv"},   out_sv, 0);
    chk({tag, "_oca"},   out_ca, 0);
    chk({tag, "_op"},    out_p, 0);
    chk({tag, "_ol"},    out_l, 0);
    chk({tag, "_cnt"},   fifo_count, 0);
`ifdef GPS_SWEEP_PARITY_EN
    chk({tag, "_par"},   out_parity, 0);
`endif
  endtask

  task automatic check_pops(input string tag, input int skip);
    int   k;
    pop_t e;
    k = 0;
    for (int s = 1; s <= 6; s++) begin
      if (s == skip) continue;
      if (k < pop_q.size()) begin
        e = pop_q[k];
        chk({tag, "_sv"}, e.sv, s);
        chk({tag, "_ca"}, e.ca, f_ca(6'(s)));
        chk({tag, "_p"},  e.p,  f_p(6'(s)));
        chk({tag, "_l"},  e.l,  f_l(6'(s)));
      end
      k++;
    end
    chk({tag, "_npop"}, pop_q.size(), k);
  endtask

  initial begin
    int done_cyc;
    rst_n = 1'b0;
    sweep_start = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check_zero("rst");
    rst_n = 1'b1;
    tick();

    // basic sweep with a stray start while busy
    out_ready = 1'b1;
    clr();
    start_sweep();
    chk("t1_svnum", sv_num, 1);
    chk("t1_launch", startRound, 1);
    chk("t1_busy", sweep_busy, 1);
    repeat (20) tick();
    start_sweep();
    wait_done("t1_done");
    done_cyc = cyc;
    chk("t1_busy_in_done", sweep_busy, 1);
    tick();
    chk("t1_done_pulse", sweep_done, 0);
    chk("t1_busy_drop", sweep_busy, 0);
    drain();
    chk("t1_nlaunch", sr_sv.size(), 6);
    for (int i = 0; i < sr_sv.size(); i++)
      chk("t1_launch_sv", sr_sv[i], i + 1);
    check_pops("t1", 0);
    if (pop_q.size() > 0)
      chk("t1_done_lat", done_cyc, pop_q[pop_q.size()-1].c);

    // stale valid held across LAUNCH
    m_hold = 2;
    m_gap = 2;
    clr();
    start_sweep();
    wait_done("t2_done");
    drain();
    chk("t2_nlaunch", sr_sv.size(), 6);
    check_pops("t2", 0);

    // backpressure: stall in PUSH for SV 5
    m_hold = 0;
    m_gap = 3;
    out_ready = 1'b0;
    clr();
    start_sweep();
    wait_cnt("t3_fill", 4);
    repeat (30) tick();
    chk("t3_cnt", fifo_count, 4);
    chk("t3_svnum", sv_num, 5);
    chk("t3_busy", sweep_busy, 1);
    chk("t3_nlaunch", sr_sv.size(), 5);
    chk("t3_head", out_sv, 1);
    chk("t3_head_l", out_l, f_l(6'd1));
    out_ready = 1'b1;
    wait_done("t3_done");
    drain();
    check_pops("t3", 0);

    // timeout on SV 2
    m_gap = 5;
    m_skip = 2;
    te_cyc = -1;
    clr();
    start_sweep();
    wait_done("t4_done");
    chk("t4_terr", timeout_err, 1);
    if (sr_cyc.size() > 1)
      chk("t4_tmo_lat", te_cyc - sr_cyc[1], 16);
    drain();
    check_pops("t4", 2);
    chk("t4_terr_sticky", timeout_err, 1);
    m_skip = 0;
    clr();
    start_sweep();
    chk("t4_terr_clr", timeout_err, 0);
    wait_done("t4b_done");
    drain();
    check_pops("t4b", 0);
    chk("t4b_terr", timeout_err, 0);

    // reset while SV 2 waits, SV 1 in FIFO
    m_gap = 10;
    out_ready = 1'b0;
    clr();
    start_sweep();
    for (int n = 0; n < 200 && sr_sv.size() < 2; n++)
      tick();
    chk("t5_sv2_launch", sr_sv.size(), 2);
    repeat (4) tick();
    chk("t5_pre_cnt", fifo_count, 1);
    chk("t5_pre_busy", sweep_busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("t5_inrst");
    tick();
    rst_n = 1'b1;
    tick();
    check_zero("t5_post");
    repeat (20) tick();
    out_ready = 1'b1;
    clr();
    start_sweep();
    wait_done("t5_done");
    drain();
    check_pops("t5", 0);

`ifdef GPS_SWEEP_PARITY_EN
    m_fix = 1'b1;
    fx_ca = 13'h0;
    fx_p = 128'h1;
    fx_l = 128'h0;
    out_ready = 1'b0;
    start_sweep();
    wait_cnt("t6a_fill", 1);
    chk("t6a_sv", out_sv, 1);
    chk("t6a_par", out_parity, 0);
    out_ready = 1'b1;
    wait_done("t6a_done");
    drain();
    chk("t6_par_empty", out_parity, 0);
    fx_ca = 13'h1;
    out_ready = 1'b0;
    start_sweep();
    wait_cnt("t6b_fill", 1);
    chk("t6b_sv", out_sv, 1);
    chk("t6b_par", out_parity, 1);
    out_ready = 1'b1;
    wait_done("t6b_done");
    drain();
    m_fix = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
